// File: rtl/instruction_fetch.sv
// Instruction fetch stage: request/grant memory port, in-order response
// buffer of two words, redirect with discard of stale responses.
module instruction_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_addr
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] baddr_q [2];
    logic [31:0] baddr_d [2];
    logic [31:0] bword_q [2];
    logic [31:0] bword_d [2];
    logic        head_q, head_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  out_q, out_d;
    logic [1:0]  disc_q, disc_d;

    logic [2:0]  inflight;
    logic        grant;
    logic        rsp;
    logic        pop;
    logic        keep;
    logic        tail;
    logic [1:0]  live;
    logic [31:0] rsp_addr;

    assign inflight   = {1'b0, out_q} + {1'b0, cnt_q};
    assign imem_req   = rst_n && (inflight < 3'd2) && !redirect_valid;
    assign imem_addr  = rst_n ? pc_q : 32'h0;
    assign inst_valid = (cnt_q != 2'd0);
    assign instruction = inst_valid ? bword_q[head_q] : 32'h0;
    assign inst_addr   = inst_valid ? baddr_q[head_q] : 32'h0;

    assign grant = imem_req & imem_gnt;
    assign rsp   = imem_rvalid & (out_q != 2'd0);
    assign pop   = inst_valid & inst_ready;
    assign keep  = rsp & (disc_q == 2'd0) & !redirect_valid;
    assign tail  = head_q ^ cnt_q[0];

    // Kept requests are contiguous and end just below pc.
    assign live     = out_q - disc_q;
    assign rsp_addr = pc_q - {28'h0, live, 2'b00};

    always_comb begin
        pc_d    = pc_q;
        baddr_d = baddr_q;
        bword_d = bword_q;
        head_d  = head_q;
        cnt_d   = cnt_q;
        out_d   = out_q + {1'b0, grant} - {1'b0, rsp};
        disc_d  = disc_q;
        if (grant) begin
            pc_d = pc_q + 32'd4;
        end
        if (rsp && disc_q != 2'd0) begin
            disc_d = disc_q - 2'd1;
        end
        if (redirect_valid) begin
            pc_d   = redirect_addr & ~32'h3;
            cnt_d  = 2'd0;
            disc_d = out_d;
        end else begin
            if (keep) begin
                baddr_d[tail] = rsp_addr;
                bword_d[tail] = imem_rdata;
            end
            cnt_d  = cnt_q + {1'b0, keep} - {1'b0, pop};
            head_d = head_q ^ pop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_ADDR;
            baddr_q[0] <= 32'h0;
            baddr_q[1] <= 32'h0;
            bword_q[0] <= 32'h0;
            bword_q[1] <= 32'h0;
            head_q     <= 1'b0;
            cnt_q      <= 2'd0;
            out_q      <= 2'd0;
            disc_q     <= 2'd0;
        end else begin
            pc_q    <= pc_d;
            baddr_q <= baddr_d;
            bword_q <= bword_d;
            head_q  <= head_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small memory model and
// in-order stream scoreboard.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] inst_addr;

    instruction_fetch #(.RESET_ADDR(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_addr      (inst_addr)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic        gnt_en = 1'b1;
    logic        rdy_en = 1'b1;
    logic        rv_en = 1'b1;
    logic        redir = 1'b0;
    logic        stale = 1'b0;
    logic [31:0] redir_to = 32'h0;
    logic [31:0] rq[$];
    logic [31:0] exp_ia = 32'h0;
    logic [31:0] exp_ga = 32'h0;
    int          grants = 0;
    int          accepts = 0;

    function automatic logic [31:0] mw(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive this cycle's inputs, then log what transfers at the next edge.
    task automatic apply();
        imem_gnt       = gnt_en;
        inst_ready     = rdy_en;
        redirect_valid = redir;
        redirect_addr  = redir_to;
        if (stale) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else if (rv_en && rq.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mw(rq[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
        if (!rst_n) return;
        if (imem_rvalid && !stale) void'(rq.pop_front());
        if (imem_req && imem_gnt) begin
            check("grant_addr", imem_addr, exp_ga);
            exp_ga += 32'd4;
            rq.push_back(imem_addr);
            grants++;
        end
        if (inst_valid && inst_ready) begin
            check("stream_addr", inst_addr, exp_ia);
            check("stream_word", instruction, mw(exp_ia));
            exp_ia += 32'd4;
            accepts++;
        end
        if (redir) begin
            exp_ia = {redir_to[31:2], 2'b00};
            exp_ga = {redir_to[31:2], 2'b00};
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        apply();
    endtask

    initial begin
        int a;
        int g0;
        logic [31:0] a0;

        cyc();
        cyc();
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_instr", instruction, 0);
        check("rst_iaddr", inst_addr, 0);

        @(negedge clk);
        rst_n = 1'b1;
        apply();
        check("first_req", imem_req, 1);
        check("first_req_addr", imem_addr, 32'h0);
        cyc();
        check("valid_early", inst_valid, 0);
        cyc();
        check("first_valid", inst_valid, 1);
        check("first_iaddr", inst_addr, 32'h0);
        check("first_word", instruction, mw(32'h0));
        repeat (10) cyc();
        check("flow_progress", {31'h0, accepts >= 4}, 1);

        rdy_en = 1'b0;
        repeat (6) cyc();
        check("bp_valid", inst_valid, 1);
        check("bp_req", imem_req, 0);
        check("bp_head", inst_addr, exp_ia);
        g0 = grants;
        repeat (3) cyc();
        check("bp_no_grant", grants, g0);
        check("bp_held_pc", imem_addr, exp_ia + 32'd8);
        a = accepts;
        rdy_en = 1'b1;
        repeat (8) cyc();
        check("bp_resume", {31'h0, accepts >= a + 3}, 1);

        gnt_en = 1'b0;
        repeat (4) cyc();
        a0 = imem_addr;
        check("stall_req", imem_req, 1);
        check("stall_addr", a0, exp_ga);
        repeat (3) begin
            cyc();
            check("stall_hold_req", imem_req, 1);
            check("stall_hold_addr", imem_addr, a0);
        end
        gnt_en = 1'b1;

        rv_en = 1'b0;
        repeat (4) cyc();
        check("two_outstanding", rq.size(), 2);
        check("credit_req", imem_req, 0);
        redir    = 1'b1;
        redir_to = 32'h0000_0103;
        rv_en    = 1'b1;
        cyc();
        check("redir_req", imem_req, 0);
        redir = 1'b0;
        cyc();
        check("redir_next_req", imem_req, 1);
        check("redir_next_addr", imem_addr, 32'h0000_0100);
        a = accepts;
        repeat (8) cyc();
        check("redir_progress", {31'h0, accepts > a}, 1);

        redir    = 1'b1;
        redir_to = 32'hFFFF_FFFC;
        cyc();
        redir = 1'b0;
        cyc();
        check("wrap_req", imem_req, 1);
        check("wrap_pc", imem_addr, 32'hFFFF_FFFC);
        cyc();
        check("wrap_next", imem_addr, 32'h0000_0000);
        repeat (8) cyc();

        rdy_en = 1'b0;
        repeat (6) cyc();
        check("full_before_rst", inst_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_addr", imem_addr, 0);
        check("mid_rst_valid", inst_valid, 0);
        check("mid_rst_instr", instruction, 0);
        check("mid_rst_iaddr", inst_addr, 0);
        rq.delete();
        exp_ia = 32'h0;
        exp_ga = 32'h0;
        rdy_en = 1'b1;
        repeat (2) cyc();
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b1;
        apply();
        stale = 1'b0;
        check("restart_req", imem_req, 1);
        check("restart_addr", imem_addr, 32'h0);
        a = accepts;
        repeat (10) cyc();
        check("restart_progress", {31'h0, accepts >= a + 3}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
